// File: rtl/parity_frame_pkg.sv
// Shared definitions for the parity frame transmitter: FSM encodings and frame geometry.
package parity_frame_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Serial bits per frame: start + W data + parity + stop.
  function automatic int frame_bits(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/parity_frame_tx_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on the last count, clears while idle.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Lets the parent register a pulse that lines up with the final clock of a bit.
  assign tick_next = (cnt_d == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Serialises a word plus its parity as start/data(LSB first)/parity/stop, with registered outputs.
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int W            = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic         parity,
  input  logic         valid,
  output logic         ready,
  output logic         tx,
  output logic         busy,
  output logic         done,
  output logic         par_mismatch
);

  localparam int IDXW = $clog2(W);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(W - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic           par_q, par_d;
  logic [IDXW-1:0] bit_idx_q, bit_idx_d;
  logic           tx_q, tx_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           mism_q, mism_d;

  logic baud_clr;
  logic tick;
  logic tick_next;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (baud_clr),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_idx_d = bit_idx_q;
    mism_d    = mism_q;
    baud_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_clr = 1'b1;
        if (valid) begin
          state_d = ST_START;
          shift_d = a;
          par_d   = parity;
          mism_d  = (parity != ^a);
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d   = ST_PARITY;
            bit_idx_d = '0;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
    done_d  = (state_d == ST_STOP) && tick_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mism_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mism_q    <= mism_d;
    end
  end

  assign tx           = tx_q;
  assign ready        = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign par_mismatch = mism_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed plus randomized checks of parity_frame_tx against a bit-list frame model.
module tb_parity_frame_tx;

  localparam int W     = 16;
  localparam int CPB   = 4;
  localparam int FRAME = (W + 3) * CPB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a;
  logic         parity;
  logic         valid;
  logic         ready, tx, busy, done, par_mismatch;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(
    .W            (W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a),
    .parity       (parity),
    .valid        (valid),
    .ready        (ready),
    .tx           (tx),
    .busy         (busy),
    .done         (done),
    .par_mismatch (par_mismatch)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit even_mismatch(input logic [W-1:0] av, input logic pv);
    return (($countones(av) % 2) != int'(pv));
  endfunction

  // Sends one word and checks every clock of the frame plus the idle clock after it.
  // With hold set, valid stays high and a/parity switch to the next word mid-frame.
  task automatic do_frame(input logic [W-1:0] av, input logic pv, input bit hold,
                          input logic [W-1:0] nav, input logic npv);
    logic exp_bits[FRAME];
    logic bitv;
    bit   exp_m;
    int   waits;

    for (int b = 0; b < W + 3; b++) begin
      if (b == 0)       bitv = 1'b0;
      else if (b <= W)  bitv = av[b-1];
      else if (b == W+1) bitv = pv;
      else              bitv = 1'b1;
      for (int c = 0; c < CPB; c++) exp_bits[b*CPB + c] = bitv;
    end
    exp_m = even_mismatch(av, pv);

    a      = av;
    parity = pv;
    valid  = 1'b1;
    waits  = 0;
    while (ready !== 1'b1) begin
      if (waits >= 200) begin
        chk("ready_timeout", 32'(ready), 32'd1);
        valid = 1'b0;
        return;
      end
      step();
      waits++;
    end
    chk("idle_tx", 32'(tx), 32'd1);
    step();
    if (!hold) valid = 1'b0;

    for (int i = 0; i < FRAME; i++) begin
      chk($sformatf("tx[%0d] a=%h", i, av), 32'(tx), 32'(exp_bits[i]));
      chk($sformatf("done[%0d]", i), 32'(done), 32'(i == FRAME - 1));
      chk($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
      chk($sformatf("mism[%0d]", i), 32'(par_mismatch), 32'(exp_m));
      if (hold && i == 30) begin
        a      = nav;
        parity = npv;
      end
      if (i < FRAME - 1) step();
    end

    step();
    chk("post_ready", 32'(ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_tx", 32'(tx), 32'd1);
    chk("post_done", 32'(done), 32'd0);
    chk("post_mism", 32'(par_mismatch), 32'(exp_m));
    $display("frame a=%h parity=%0d mismatch=%0d hold=%0d", av, pv, exp_m, hold);
  endtask

  initial begin
    logic [W-1:0] cur_a, nxt_a;
    logic         cur_p, nxt_p;

    rst_n  = 1'b0;
    valid  = 1'b0;
    a      = '0;
    parity = 1'b0;
    repeat (3) step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mism", 32'(par_mismatch), 32'd0);
    chk("rst_no_x", 32'($isunknown({tx, ready, busy, done, par_mismatch})), 32'd0);
    rst_n = 1'b1;
    step();

    do_frame(16'h0001, 1'b1, 1'b0, '0, 1'b0);
    do_frame(16'hA5A5, 1'b0, 1'b0, '0, 1'b0);
    do_frame(16'h0003, 1'b1, 1'b0, '0, 1'b0);

    // Valid held: the word changes mid-frame and must only be taken once idle again.
    do_frame(16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    do_frame(16'hFFFF, 1'b0, 1'b0, '0, 1'b0);

    // Reset pulsed during data bit 7, then a clean frame.
    a      = 16'h5A5A;
    parity = 1'b0;
    valid  = 1'b1;
    step();
    valid = 1'b0;
    repeat (CPB + 7*CPB + 1) step();
    chk("pre_rst_tx_bit7", 32'(tx), 32'(a[7]));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_ready", 32'(ready), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("in_rst_done", 32'(done), 32'd0);
      chk("in_rst_tx", 32'(tx), 32'd1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("after_rst_done", 32'(done), 32'd0);
      chk("after_rst_ready", 32'(ready), 32'd1);
    end
    $display("reset mid-frame exercised");
    do_frame(16'h8000, 1'b1, 1'b0, '0, 1'b0);

    // Random back-to-back words, roughly a quarter with deliberately wrong parity.
    cur_a = 16'($urandom);
    cur_p = 1'(($countones(cur_a) % 2) ^ int'($urandom_range(0, 3) == 0));
    for (int n = 0; n < 24; n++) begin
      nxt_a = 16'($urandom);
      nxt_p = 1'(($countones(nxt_a) % 2) ^ int'($urandom_range(0, 3) == 0));
      do_frame(cur_a, cur_p, 1'b1, nxt_a, nxt_p);
      cur_a = nxt_a;
      cur_p = nxt_p;
    end
    valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
